// File: rtl/mem_stream_loader.sv
// Serial-to-memory loader: assembles received bytes MSB-first into 32-bit words,
// writes each nonzero word to consecutive addresses, and echoes every byte.
// A zero word (or reaching MAX_WORDS) ends the load with a terminator word.
module mem_stream_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] TERMINATOR = 32'hE3A0_F000,
  parameter int unsigned MAX_WORDS  = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [31:0] mem_address,
  output logic        mem_write_en,
  output logic [31:0] mem_write_data,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [15:0] word_count,
  output logic [31:0] end_addr
);

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StWrite,
    StTerm,
    StDone
  } state_e;

  localparam logic [15:0] MaxCount = 16'(MAX_WORDS);

  state_e      state_q, state_d;

  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        overflow_q, overflow_d;
  logic [15:0] word_count_q, word_count_d;
  logic [31:0] end_addr_q, end_addr_d;

  logic        accept;
  logic        last_byte;
  logic [31:0] word_next;
  logic        at_max;

  assign accept    = rx_valid && rx_ready;
  assign last_byte = accept && (byte_cnt_q == 2'd3);
  assign word_next = {word_q[23:0], rx_data};
  // Count after the current WRITE state retires its word.
  assign at_max    = (word_count_q + 16'd1) == MaxCount;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (last_byte) begin
          state_d = (word_next == 32'd0) ? StTerm : StWrite;
        end
      end
      StWrite: begin
        state_d = at_max ? StTerm : StCollect;
      end
      StTerm: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from state; rx_ready also looks at echo-sink readiness so the
  // echo register is always free when a byte is accepted.
  always_comb begin
    rx_ready     = (state_q == StCollect) && (!tx_valid_q || tx_ready);
    mem_write_en = (state_q == StWrite) || (state_q == StTerm);
  end

  // Datapath next-state: word assembly, addressing, echo and status.
  always_comb begin
    word_d           = word_q;
    addr_d           = addr_q;
    byte_cnt_d       = byte_cnt_q;
    tx_valid_d       = tx_valid_q;
    tx_data_d        = tx_data_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    busy_d           = busy_q;
    done_d           = done_q;
    overflow_d       = overflow_q;
    word_count_d     = word_count_q;
    end_addr_d       = end_addr_q;

    // Echo drains in every state.
    if (accept) begin
      tx_valid_d = 1'b1;
      tx_data_d  = rx_data;
    end else if (tx_ready) begin
      tx_valid_d = 1'b0;
    end

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          addr_d       = BASE_ADDR;
          byte_cnt_d   = 2'd0;
          word_d       = 32'd0;
          word_count_d = 16'd0;
          done_d       = 1'b0;
          overflow_d   = 1'b0;
          busy_d       = 1'b1;
        end
      end
      StCollect: begin
        if (accept) begin
          word_d     = word_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
        // Preload the write bus so it is stable for the whole write cycle.
        if (last_byte) begin
          mem_address_d    = addr_q;
          mem_write_data_d = (word_next == 32'd0) ? TERMINATOR : word_next;
        end
      end
      StWrite: begin
        addr_d       = addr_q + 32'd4;
        word_count_d = word_count_q + 16'd1;
        if (at_max) begin
          overflow_d       = 1'b1;
          mem_address_d    = addr_q + 32'd4;
          mem_write_data_d = TERMINATOR;
        end
      end
      StTerm: begin
        end_addr_d = addr_q + 32'd4;
        busy_d     = 1'b0;
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q           <= 32'd0;
      addr_q           <= 32'd0;
      byte_cnt_q       <= 2'd0;
      tx_valid_q       <= 1'b0;
      tx_data_q        <= 8'd0;
      mem_address_q    <= 32'd0;
      mem_write_data_q <= 32'd0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      overflow_q       <= 1'b0;
      word_count_q     <= 16'd0;
      end_addr_q       <= 32'd0;
    end else begin
      word_q           <= word_d;
      addr_q           <= addr_d;
      byte_cnt_q       <= byte_cnt_d;
      tx_valid_q       <= tx_valid_d;
      tx_data_q        <= tx_data_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      overflow_q       <= overflow_d;
      word_count_q     <= word_count_d;
      end_addr_q       <= end_addr_d;
    end
  end

  assign tx_valid       = tx_valid_q;
  assign tx_data        = tx_data_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign overflow       = overflow_q;
  assign word_count     = word_count_q;
  assign end_addr       = end_addr_q;

endmodule
